// File: rtl/demux_scan_controller_if.sv
// rtl/demux_scan_controller_if.sv - word handshake and demux drive signals for the scan controller
//
// Purpose: bundles the upstream word handshake, the abort strobe and the
// demux drive/status outputs of demux_scan_controller.
// Signals:
//   in_valid, in_data[7:0], in_ready : upstream word handshake
//   abort                            : synchronous abort of the scan in progress
//   d, s0, s1, s2                    : demux data and select lines
//   busy, done                       : scan status
// Modports:
//   master : upstream side (drives the word and abort, observes the rest)
//   slave  : controller side

interface demux_scan_controller_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       abort;
  logic       d;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, d, s0, s1, s2, busy, done
  );

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, d, s0, s1, s2, busy, done
  );
endinterface

// File: rtl/demux_scan_controller.sv
// rtl/demux_scan_controller.sv - serialises an 8-bit word onto a 1-to-8 demux with programmable dwell
//
// Purpose: accepts one word per handshake, then walks the demux selects
// through channels 0..7, holding each for DWELL cycles while driving the
// matching data bit on d. A one-cycle done pulse follows a complete scan.
// Parameters:
//   DWELL : cycles each channel is held, 1..15
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of demux_scan_controller_if

module demux_scan_controller #(
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_scan_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t     r_state;
  logic [7:0] r_data;
  logic [2:0] r_idx;
  logic [3:0] r_dwell;
  logic       r_d;
  logic [2:0] r_sel;
  logic       r_busy;
  logic       r_done;
  logic       r_ready;

  logic [2:0] w_idx_next;
  logic       w_dwell_end;

  assign w_idx_next  = r_idx + 3'd1;
  assign w_dwell_end = (r_dwell == DWELL_LAST);

  // d and the selects are loaded on the same edge from the same index, so the
  // demux never sees a new channel with the previous channel's data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= 8'h00;
      r_idx   <= 3'd0;
      r_dwell <= 4'd0;
      r_d     <= 1'b0;
      r_sel   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // in_ready is always high here, so in_valid alone completes the handshake.
          if (bus.in_valid) begin
            r_data  <= bus.in_data;
            r_idx   <= 3'd0;
            r_dwell <= 4'd0;
            r_d     <= bus.in_data[0];
            r_sel   <= 3'd0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (bus.abort) begin
            r_idx   <= 3'd0;
            r_dwell <= 4'd0;
            r_d     <= 1'b0;
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_dwell_end) begin
            r_dwell <= 4'd0;
            if (r_idx == 3'd7) begin
              r_d     <= 1'b0;
              r_sel   <= 3'd0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx <= w_idx_next;
              r_sel <= w_idx_next;
              r_d   <= r_data[w_idx_next];
            end
          end else begin
            r_dwell <= r_dwell + 4'd1;
          end
        end

        ST_DONE: begin
          // in_ready stays low through DONE so a held in_valid waits for IDLE.
          r_idx   <= 3'd0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_d     <= 1'b0;
          r_sel   <= 3'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.d        = r_d;
  assign bus.s0       = r_sel[0];
  assign bus.s1       = r_sel[1];
  assign bus.s2       = r_sel[2];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_demux_scan_controller.sv
// tb/tb_demux_scan_controller.sv - directed self-checking bench for demux_scan_controller
//
// Purpose: drives three controller instances (DWELL 1, 2 and 3) through reset,
// single-word scans, back-to-back words, abort and reset mid-scan.
// Observed outputs are packed as {busy, done, in_ready, s2, s1, s0, d}.

module tb_demux_scan_controller;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  demux_scan_controller_if if1 ();
  demux_scan_controller_if if2 ();
  demux_scan_controller_if if3 ();

  demux_scan_controller #(.DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  demux_scan_controller #(.DWELL(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  demux_scan_controller #(.DWELL(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic [6:0] o1, o2, o3;
  assign o1 = {if1.busy, if1.done, if1.in_ready, if1.s2, if1.s1, if1.s0, if1.d};
  assign o2 = {if2.busy, if2.done, if2.in_ready, if2.s2, if2.s1, if2.s0, if2.d};
  assign o3 = {if3.busy, if3.done, if3.in_ready, if3.s2, if3.s1, if3.s0, if3.d};

  localparam logic [6:0] EXP_IDLE = 7'b0010000;
  localparam logic [6:0] EXP_DONE = 7'b0100000;

  function automatic logic [6:0] exp_scan(input int sel, input logic dbit);
    logic [2:0] s;
    s = 3'(sel);
    return {1'b1, 1'b0, 1'b0, s, dbit};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o1 !== EXP_IDLE) begin n_errors++; $display("FAIL reset_idle1: got %b expected %b", o1, EXP_IDLE); end
    n_checks++;
    if (o2 !== EXP_IDLE) begin n_errors++; $display("FAIL reset_idle2: got %b expected %b", o2, EXP_IDLE); end
    n_checks++;
    if (o3 !== EXP_IDLE) begin n_errors++; $display("FAIL reset_idle3: got %b expected %b", o3, EXP_IDLE); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b1;
    if1.in_data  = 8'h3D;
    @(posedge clk);
    #2;
    n_checks++;
    if (o1 !== exp_scan(0, 1'b1)) begin n_errors++; $display("FAIL reset_pre_scan: got %b expected %b", o1, exp_scan(0, 1'b1)); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o1 !== EXP_IDLE) begin n_errors++; $display("FAIL reset_async: got %b expected %b", o1, EXP_IDLE); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o1 !== exp_scan(0, 1'b1)) begin n_errors++; $display("FAIL reset_first_accept: got %b expected %b", o1, exp_scan(0, 1'b1)); end
    if1.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (o1 !== EXP_IDLE) begin n_errors++; $display("FAIL reset_recover: got %b expected %b", o1, EXP_IDLE); end
  endtask

  task automatic test_single_dwell1;
    logic [7:0] w;
    logic [6:0] e;
    w = 8'hA5;
    @(posedge clk); #1;
    if1.in_valid = 1'b1;
    if1.in_data  = w;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    if1.in_data  = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8)       e = exp_scan(k - 1, w[3'(k - 1)]);
      else if (k == 9)  e = EXP_DONE;
      else              e = EXP_IDLE;
      n_checks++;
      if (o1 !== e) begin n_errors++; $display("FAIL single cycle %0d: got %b expected %b", k, o1, e); end
    end
  endtask

  task automatic test_dwell3;
    logic [7:0] w;
    logic [6:0] e;
    int sel;
    w = 8'h81;
    @(posedge clk); #1;
    if3.in_valid = 1'b1;
    if3.in_data  = w;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    if3.in_data  = 8'hFF;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      sel = (k - 1) / 3;
      if (k <= 24)       e = exp_scan(sel, w[3'(sel)]);
      else if (k == 25)  e = EXP_DONE;
      else               e = EXP_IDLE;
      n_checks++;
      if (o3 !== e) begin n_errors++; $display("FAIL dwell3 cycle %0d: got %b expected %b", k, o3, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] e;
    int n_done;
    n_done = 0;
    @(posedge clk); #1;
    if1.in_valid = 1'b1;
    if1.in_data  = 8'hFF;
    @(posedge clk); #1;
    if1.in_data  = 8'h00;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k <= 8)                  e = exp_scan(k - 1, 1'b1);
      else if (k == 9 || k == 19)  e = EXP_DONE;
      else if (k == 10)            e = EXP_IDLE;
      else if (k <= 18)            e = exp_scan(k - 11, 1'b0);
      else                         e = EXP_IDLE;
      if (if1.done === 1'b1) n_done++;
      n_checks++;
      if (o1 !== e) begin n_errors++; $display("FAIL b2b cycle %0d: got %b expected %b", k, o1, e); end
      if (k == 11) if1.in_valid = 1'b0;
    end
    n_checks++;
    if (n_done !== 2) begin n_errors++; $display("FAIL b2b_done_count: got %0d expected %0d", n_done, 2); end
  endtask

  task automatic test_abort;
    logic [7:0] w;
    logic [6:0] e;
    int sel;
    @(posedge clk); #1;
    if2.in_valid = 1'b1;
    if2.in_data  = 8'hFF;
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = exp_scan((k - 1) / 2, 1'b1);
      n_checks++;
      if (o2 !== e) begin n_errors++; $display("FAIL abort_pre cycle %0d: got %b expected %b", k, o2, e); end
    end
    if2.abort = 1'b1;
    @(posedge clk); #1;
    if2.abort = 1'b0;
    for (int k = 10; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (o2 !== EXP_IDLE) begin n_errors++; $display("FAIL abort_post cycle %0d: got %b expected %b", k, o2, EXP_IDLE); end
    end
    w = 8'h0F;
    @(posedge clk); #1;
    if2.in_valid = 1'b1;
    if2.in_data  = w;
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      sel = (k - 1) / 2;
      if (k <= 16)       e = exp_scan(sel, w[3'(sel)]);
      else if (k == 17)  e = EXP_DONE;
      else               e = EXP_IDLE;
      n_checks++;
      if (o2 !== e) begin n_errors++; $display("FAIL abort_rescan cycle %0d: got %b expected %b", k, o2, e); end
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [7:0] w;
    logic [6:0] e;
    @(posedge clk); #1;
    if1.in_valid = 1'b1;
    if1.in_data  = 8'hFF;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = exp_scan(k - 1, 1'b1);
      n_checks++;
      if (o1 !== e) begin n_errors++; $display("FAIL rstmid_pre cycle %0d: got %b expected %b", k, o1, e); end
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o1 !== EXP_IDLE) begin n_errors++; $display("FAIL rstmid_async: got %b expected %b", o1, EXP_IDLE); end
    #1 rst_n = 1'b1;
    w = 8'h02;
    @(posedge clk); #1;
    if1.in_valid = 1'b1;
    if1.in_data  = w;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8)       e = exp_scan(k - 1, w[3'(k - 1)]);
      else if (k == 9)  e = EXP_DONE;
      else              e = EXP_IDLE;
      n_checks++;
      if (o1 !== e) begin n_errors++; $display("FAIL rstmid_rescan cycle %0d: got %b expected %b", k, o1, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.abort = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = 8'h00; if2.abort = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = 8'h00; if3.abort = 1'b0;
    test_reset();
    test_single_dwell1();
    test_dwell3();
    test_back_to_back();
    test_abort();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_scan_controller.md
# demux_scan_controller

Upstream driver for the 1-to-8 demultiplexer. Accepts one 8-bit word per valid/ready handshake and serialises it onto the demux data line `d`. It steps the select lines `s2..s0` through channels 0..7, holding each channel for a programmable dwell time, so demux output `yN` carries bit N of the word. Outputs are registered and drive the demux `d`/`s0`/`s1`/`s2` inputs directly.

## Interface
- `DWELL`, default 1: cycles each channel is held. Legal range 1..15; dwell counter is 4 bits wide.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream word valid.
- `in_data` in 8: word to distribute; bit N goes to channel N.
- `in_ready` out 1: block can accept a word.
- `abort` in 1: synchronous abort of the scan in progress.
- `d` out 1: demux data input.
- `s0`, `s1`, `s2` out 1 each: demux select; `{s2,s1,s0}` is the current channel index.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse after a scan completes normally.

## Operation
- States: IDLE, SCAN, DONE. The encoding is implementation choice.
- Registers:
  - `data_q[7:0]`: captured word.
  - `idx[2:0]`: channel index.
  - `dwell_cnt[3:0]`: cycles spent on the current channel.
- IDLE:
  - `in_ready=1`, `busy=0`, `d=0`, `{s2,s1,s0}=0`, `done=0`.
  - `in_valid && in_ready` at an edge: capture `in_data` into `data_q`, set `idx=0`, `dwell_cnt=0`, go to SCAN.
  - `in_valid` low: stay in IDLE.
  - `abort` is ignored in IDLE.
- SCAN:
  - `in_ready=0`, `busy=1`, `{s2,s1,s0}=idx`, `d=data_q[idx]`.
  - Each edge increments `dwell_cnt`.
  - When `dwell_cnt==DWELL-1`: clear `dwell_cnt` and increment `idx`.
  - When `idx==7` and `dwell_cnt==DWELL-1`: go to DONE. `idx` does not wrap into a second pass.
- DONE:
  - Lasts exactly one cycle: `done=1`, `busy=0`, `in_ready=0`, `d=0`, `{s2,s1,s0}=0`.
  - Then go to IDLE unconditionally.
- Abort:
  - `abort` high at an edge while in SCAN: go to IDLE, `d=0`, selects=0, no `done` pulse.
  - `abort` has priority over the dwell/idx advance on that edge. `data_q` contents are then don't-care.
- `d` and the selects are registered and update on the same edge, so the demux never sees a select change without the matching data bit.
- `in_data` is sampled only at the accepting edge. Later changes have no effect on the scan.

## Timing
- Reset (rst_n low, asynchronous):
  - State=IDLE, `idx=0`, `dwell_cnt=0`, `data_q=0`.
  - `d=0`, `s0=s1=s2=0`, `busy=0`, `done=0`, `in_ready=1`.
  - Reset asserted mid-scan forces these values immediately, with no `done` pulse.
- Accept edge E0: from the cycle after E0, `d=in_data[0]`, selects=0, `busy=1`.
- Channel N is presented during cycles E0+N·DWELL+1 .. E0+(N+1)·DWELL.
- `done=1` during the cycle after edge E0+8·DWELL. `in_ready=1` again one cycle later.
- Throughput: one word per 8·DWELL+2 cycles with `in_valid` held continuously high.
- A held `in_valid` is accepted on the first IDLE edge; the word is never accepted during DONE.

## Test plan
- **Reset values.** Assert `rst_n=0` asynchronously mid-cycle with `in_valid=1`.
  - Required: outputs go to `d=0`, selects 0, `busy=0`, `done=0`, `in_ready=1` without waiting for a clock edge.
  - Required: after release, the word is accepted on the first edge.
- **Single word, DWELL=1.** Send `in_data=0xA5`.
  - Required: over 8 cycles `{s2,s1,s0}` = 0,1,…,7 with `d` = 1,0,1,0,0,1,0,1.
  - Required: `done` high in cycle 9 only; `in_ready` high in cycle 10.
- **DWELL=3.** Send `in_data=0x81`.
  - Required: `d=1` for 3 cycles at select 0.
  - Required: `d=0` for 18 cycles across selects 1..6.
  - Required: `d=1` for 3 cycles at select 7.
  - Required: `done` in cycle 25.
- **Back-to-back.** Hold `in_valid=1` with words 0xFF then 0x00 (DWELL=1).
  - Required: second accept on the edge after the DONE cycle; no word lost or duplicated.
  - Required: `d` stays 0 throughout the second scan.
- **Abort.** Send 0xFF (DWELL=2) and assert `abort` while `idx=4`.
  - Required: the next cycle is IDLE, `d=0`, selects 0, `done` never pulses.
  - Required: a new word 0x0F is accepted and scans correctly.
- **Reset mid-scan.** Send 0xFF and drop `rst_n` at select 5.
  - Required: immediate return to reset values.
  - Required: the next accepted word starts again from channel 0.
